// File: rtl/nfc_arb_pkg.sv
// nfc_arb_pkg: shared state encoding, index width helper and CE phase mapping
package nfc_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_GUARD = 2'd2} arb_state_e;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [1:0] ce_phase(input logic g);
    return {2{~g}};
  endfunction
endpackage

// File: rtl/nfc_rr_pick.sv
// nfc_rr_pick: combinational round-robin pick starting after last_idx
module nfc_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  always_comb begin
    onehot = '0;
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last_idx) + k) % N);
      if (eligible[c]) begin
        onehot = '0;
        onehot[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/nfc_way_arbiter.sv
// nfc_way_arbiter: round-robin DQ bus arbiter across NAND ways with guard gap and hold watchdog
module nfc_way_arbiter
  import nfc_arb_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int GuardCycles = 2,
  parameter int MaxHoldCycles = 0
) (
  input  logic                                  iSystemClock,
  input  logic                                  iReset,
  input  logic [NumberOfWays-1:0]               iReadyBusy,
  input  logic [NumberOfWays-1:0]               iWayRequest,
  input  logic [NumberOfWays-1:0]               iWayIgnoreRB,
  input  logic [NumberOfWays-1:0]               iWayRelease,
  output logic [NumberOfWays-1:0]               oWayGrant,
  output logic                                  oGrantValid,
  output logic [idx_width(NumberOfWays)-1:0]    oGrantIndex,
  output logic [2*NumberOfWays-1:0]             oPHY_ChipEnable,
  output logic                                  oTimeout
);
  localparam int IW = idx_width(NumberOfWays);
  localparam int HW = idx_width(MaxHoldCycles);
  localparam int GW = idx_width(GuardCycles);
  arb_state_e state_q, state_d;
  logic [NumberOfWays-1:0] grant_q, grant_d, eligible, pick_oh;
  logic [IW-1:0] index_q, index_d, last_q, last_d, pick_idx;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] guard_q, guard_d;
  logic timeout_q, timeout_d, release_hit, expire, start;
  logic [2*NumberOfWays-1:0] ce_q, ce_d;
  assign eligible = iWayRequest & (iReadyBusy | iWayIgnoreRB);
  nfc_rr_pick #(.N(NumberOfWays), .IW(IW)) u_pick (
    .eligible(eligible),
    .last_idx(last_q),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  always_comb begin
    release_hit = |(iWayRelease & grant_q);
    expire = (MaxHoldCycles > 0) && (hold_q == HW'(MaxHoldCycles - 1));
    start = (state_q == ST_IDLE) || (state_q == ST_GUARD && guard_q == GW'(GuardCycles - 1));
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    last_d = last_q;
    hold_d = hold_q;
    guard_d = guard_q;
    timeout_d = 1'b0;
    if (start) begin
      state_d = ST_IDLE;
      guard_d = '0;
      if (|eligible) begin
        state_d = ST_GRANT;
        grant_d = pick_oh;
        index_d = pick_idx;
        last_d = pick_idx;
        hold_d = '0;
      end
    end else if (state_q == ST_GUARD) begin
      guard_d = guard_q + 1'b1;
    end else if (state_q == ST_GRANT) begin
      if (release_hit || expire) begin
        grant_d = '0;
        timeout_d = !release_hit;
        state_d = (GuardCycles > 0) ? ST_GUARD : ST_IDLE;
        guard_d = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      grant_d = '0;
    end
  end
  for (genvar i = 0; i < NumberOfWays; i++) begin : g_ce
    assign ce_d[2*i +: 2] = ce_phase(grant_d[i]);
  end
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      index_q <= '0;
      last_q <= IW'(NumberOfWays - 1);
      hold_q <= '0;
      guard_q <= '0;
      timeout_q <= 1'b0;
      ce_q <= '1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      last_q <= last_d;
      hold_q <= hold_d;
      guard_q <= guard_d;
      timeout_q <= timeout_d;
      ce_q <= ce_d;
    end
  end
  assign oWayGrant = grant_q;
  assign oGrantValid = |grant_q;
  assign oGrantIndex = index_q;
  assign oPHY_ChipEnable = ce_q;
  assign oTimeout = timeout_q;
endmodule

// File: tb/tb_nfc_way_arbiter.sv
// tb_nfc_way_arbiter: directed self-checking bench for nfc_way_arbiter
module tb_nfc_way_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] rb, req, ign, rel;
  logic [3:0] grant;
  logic valid, timeout;
  logic [1:0] gidx;
  logic [7:0] ce;
  int checks = 0;
  int errors = 0;
  int order [6] = '{0, 1, 2, 3, 0, 1};
  always #5 clk = ~clk;
  nfc_way_arbiter #(.NumberOfWays(4), .GuardCycles(2), .MaxHoldCycles(8)) dut (
    .iSystemClock(clk),
    .iReset(rst),
    .iReadyBusy(rb),
    .iWayRequest(req),
    .iWayIgnoreRB(ign),
    .iWayRelease(rel),
    .oWayGrant(grant),
    .oGrantValid(valid),
    .oGrantIndex(gidx),
    .oPHY_ChipEnable(ce),
    .oTimeout(timeout)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ce_of(input logic [3:0] g);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = {2{~g[i]}};
    return r;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_idx"}, 32'(gidx), 0);
    chk({tag, "_ce"}, 32'(ce), 32'hff);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask
  initial begin
    rst = 1'b1; rb = 4'b0; req = 4'b0; ign = 4'b0; rel = 4'b0;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0; req = 4'b0101; rb = 4'b1111;
    tick();
    chk("first_grant", 32'(grant), 32'b0001);
    chk("first_valid", 32'(valid), 1);
    chk("first_idx", 32'(gidx), 0);
    chk("first_ce", 32'(ce), 32'b11111100);
    req = 4'b1111;
    tick();
    chk("hold_other_req", 32'(grant), 32'b0001);
    req = 4'b0101; rel = 4'b0100;
    tick();
    chk("foreign_release", 32'(grant), 32'b0001);
    rel = 4'b0001;
    tick();
    rel = 4'b0;
    chk("release_clear", 32'(grant), 0);
    chk("release_ce", 32'(ce), 32'hff);
    chk("release_no_to", 32'(timeout), 0);
    rel = 4'b0100;
    tick();
    rel = 4'b0;
    chk("guard2", 32'(grant), 0);
    tick();
    chk("rr_next_grant", 32'(grant), 32'b0100);
    chk("rr_next_idx", 32'(gidx), 2);
    chk("rr_next_ce", 32'(ce), 32'b11001111);
    rel = 4'b0100;
    tick();
    rel = 4'b0; req = 4'b0010; rb = 4'b1101; ign = 4'b0;
    tick(); tick(); tick();
    chk("busy_no_grant", 32'(grant), 0);
    chk("idx_held", 32'(gidx), 2);
    ign = 4'b0010;
    tick();
    chk("ignore_rb_grant", 32'(grant), 32'b0010);
    chk("ignore_rb_idx", 32'(gidx), 1);
    for (int n = 0; n < 7; n++) tick();
    chk("wd_still_held", 32'(grant), 32'b0010);
    chk("wd_no_early_to", 32'(timeout), 0);
    tick();
    chk("wd_revoke", 32'(grant), 0);
    chk("wd_timeout", 32'(timeout), 1);
    tick();
    chk("wd_pulse_end", 32'(timeout), 0);
    tick();
    chk("wd_regrant", 32'(grant), 32'b0010);
    for (int n = 0; n < 7; n++) tick();
    rel = 4'b0010;
    tick();
    rel = 4'b0;
    chk("rel_vs_wd_grant", 32'(grant), 0);
    chk("rel_vs_wd_to", 32'(timeout), 0);
    rst = 1'b1;
    tick();
    chk_reset("reset2");
    rst = 1'b0; req = 4'b1111; rb = 4'b1111; ign = 4'b0;
    tick();
    for (int n = 0; n < 6; n++) begin
      chk("rr_grant", 32'(grant), 32'(4'b1 << order[n]));
      chk("rr_idx", 32'(gidx), 32'(order[n]));
      chk("rr_ce", 32'(ce), 32'(ce_of(4'b1 << order[n])));
      tick(); tick();
      rel = 4'b1 << order[n];
      tick();
      rel = 4'b0;
      chk("rr_gap", 32'(grant), 0);
      tick(); tick();
    end
    chk("way2_grant", 32'(grant), 32'b0100);
    tick();
    rst = 1'b1;
    tick();
    chk_reset("abort");
    rst = 1'b0;
    tick();
    chk("post_reset_grant", 32'(grant), 32'b0001);
    chk("post_reset_idx", 32'(gidx), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
